// File: rtl/traffic_lamp_driver.sv
// Traffic lamp driver: glitch-filtered lamp latch, illegal-pattern fault
// with yellow flashing, optional PWM dimming under LAMP_PWM_EN.
module traffic_lamp_driver #(
  parameter int FAULT_CYCLES = 4,
  parameter int FLASH_HALF   = 50,
  parameter int PWM_BITS     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                red_in,
  input  logic                yellow_in,
  input  logic                green_in,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                fault_clr,
  output logic                lamp_red,
  output logic                lamp_yellow,
  output logic                lamp_green,
  output logic                fault
);

  localparam int CW = $clog2(FAULT_CYCLES + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] ILL_LAST = CW'(FAULT_CYCLES - 1);
  localparam logic [CW-1:0] ILL_MAX  = CW'(FAULT_CYCLES);
  localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_HALF - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      held_q, held_d;
  logic [CW-1:0]   ill_q, ill_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic            flash_on_q, flash_on_d;
  logic [2:0]      lamp_q, lamp_d;
  logic [2:0]      req;
  logic            legal;
  logic            pwm_on;

  assign req   = {red_in, yellow_in, green_in};
  assign legal = (req == 3'b100) | (req == 3'b010) | (req == 3'b001);

`ifdef LAMP_PWM_EN
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  // Lamp flop is loaded with the gate for the counter value it will show.
  always_comb begin
    pwm_d  = pwm_q + 1'b1;
    duty_d = (pwm_q == '1) ? duty : duty_q;
    pwm_on = pwm_d < duty_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
    end else begin
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pwm_on      = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    ill_d      = ill_q;
    flash_d    = flash_q;
    flash_on_d = flash_on_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (legal) begin
          held_d = req;
          ill_d  = '0;
        end else if (ill_q == ILL_LAST) begin
          state_d    = ST_FAULT;
          ill_d      = ILL_MAX;
          flash_d    = '0;
          flash_on_d = 1'b1;
        end else if (ill_q != ILL_MAX) begin
          ill_d = ill_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr && legal) begin
          state_d    = ST_NORMAL;
          held_d     = req;
          ill_d      = '0;
          flash_d    = '0;
          flash_on_d = 1'b0;
        end else if (flash_q == FL_LAST) begin
          flash_d    = '0;
          flash_on_d = ~flash_on_q;
        end else begin
          flash_d = flash_q + 1'b1;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Flashing in fault ignores the PWM gate.
  always_comb begin
    lamp_d = held_d & {3{pwm_on}};
    if (state_d == ST_FAULT) begin
      lamp_d = {1'b0, flash_on_d, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_NORMAL;
      held_q     <= '0;
      ill_q      <= '0;
      flash_q    <= '0;
      flash_on_q <= 1'b0;
      lamp_q     <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      ill_q      <= ill_d;
      flash_q    <= flash_d;
      flash_on_q <= flash_on_d;
      lamp_q     <= lamp_d;
    end
  end

  assign lamp_red    = lamp_q[2];
  assign lamp_yellow = lamp_q[1];
  assign lamp_green  = lamp_q[0];
  assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver: vector table plus
// flash timing, clear and asynchronous reset sequences.
module tb_traffic_lamp_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       red_in = 1'b0;
  logic       yellow_in = 1'b0;
  logic       green_in = 1'b0;
  logic [7:0] duty = 8'd0;
  logic       fault_clr = 1'b0;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       fault;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  traffic_lamp_driver #(
    .FAULT_CYCLES(4),
    .FLASH_HALF(50),
    .PWM_BITS(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .red_in(red_in),
    .yellow_in(yellow_in),
    .green_in(green_in),
    .duty(duty),
    .fault_clr(fault_clr),
    .lamp_red(lamp_red),
    .lamp_yellow(lamp_yellow),
    .lamp_green(lamp_green),
    .fault(fault)
  );

  typedef struct {
    logic       r;
    logic       y;
    logic       g;
    logic       clr;
    logic [2:0] lamps;
    logic       flt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic drive(input logic r, input logic y, input logic g,
                       input logic clr);
    red_in    = r;
    yellow_in = y;
    green_in  = g;
    fault_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {lamp_red, lamp_yellow, lamp_green, fault};
  endfunction

  initial begin
    // r y g clr -> lamps(rgy order r,y,g) fault
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0};

    #12;
    chk("reset_state", outs(), 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r, vecs[i].y, vecs[i].g, vecs[i].clr);
      step();
      chk($sformatf("vec%0d", i), outs(), {vecs[i].lamps, vecs[i].flt});
    end

    // Four illegal cycles: fault only after the fourth edge
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pre_fault%0d", i), outs(), 4'b1000);
    end
    step();
    chk("fault_entry", outs(), 4'b0101);
    for (int i = 1; i < 50; i++) begin
      step();
      chk($sformatf("flash_on%0d", i), outs(), 4'b0101);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("flash_off%0d", i), outs(), 4'b0001);
    end
    step();
    chk("flash_on_again", outs(), 4'b0101);

    // Clear with illegal input is ignored, legal green clears
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("clr_illegal", outs(), 4'b0101);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("clr_green", outs(), 4'b0010);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("post_clr_green", outs(), 4'b0010);

    // Enter fault again, then reset asynchronously mid-flash
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("fault_before_rst", outs(), 4'b0101);
    reset_n = 1'b0;
    #2;
    chk("async_reset", outs(), 4'b0000);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("after_release", outs(), 4'b0000);
    step();
    chk("first_after_rst", outs(), 4'b1000);

`ifdef LAMP_PWM_EN
    begin
      int cnt;
      int dm;
      int pre;
      reset_n = 1'b0;
      duty = 8'd64;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      @(negedge clk);
      reset_n = 1'b1;
      cnt = 0;
      dm = 0;
      for (int i = 0; i < 800; i++) begin
        if (i == 640) duty = 8'd0;
        pre = cnt;
        if (pre == 255) dm = int'(duty);
        cnt = (pre + 1) % 256;
        step();
        chk($sformatf("pwm%0d", i), {3'b000, lamp_green},
            {3'b000, (cnt < dm) ? 1'b1 : 1'b0});
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_driver.md
TRAFFIC_LAMP_DRIVER -- requirements
Module: traffic_lamp_driver

Interface
REQ-001 SHALL have parameter FAULT_CYCLES, default 4: consecutive illegal-pattern cycles that trigger fault.
REQ-002 SHALL have parameter FLASH_HALF, default 50: yellow flash half-period in clk cycles while in fault.
REQ-003 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports red_in, yellow_in, green_in  input  1 each  lamp request from the upstream traffic light controller.
REQ-007 SHALL have port duty  input  PWM_BITS  lamp brightness duty value.
REQ-008 SHALL have port fault_clr  input  1  operator fault-clear pulse.
REQ-009 SHALL have ports lamp_red, lamp_yellow, lamp_green  output  1 each  registered lamp drive.
REQ-010 SHALL have port fault  output  1  high while in the FAULT state.

Function
REQ-011 SHALL classify a cycle as legal when exactly one of red_in/yellow_in/green_in is high, otherwise illegal (none or more than one).
REQ-012 SHALL implement two FSM states, NORMAL and FAULT.
REQ-013 In NORMAL, on a legal cycle SHALL latch the input pattern into a held-pattern register; lamp outputs reflect it 1 cycle later (latency 1, PWM excluded).
REQ-014 In NORMAL, on an illegal cycle SHALL keep the held pattern unchanged (glitch filter) and increment an illegal counter; a legal cycle resets the counter to 0.
REQ-015 SHALL move NORMAL -> FAULT on the edge where the illegal counter would reach FAULT_CYCLES; the counter saturates and never wraps.
REQ-016 In FAULT, lamp_red and lamp_green SHALL be 0; lamp_yellow SHALL be 1 in the first cycle after entry and toggle every FLASH_HALF cycles.
REQ-017 In FAULT, fault SHALL be 1; in NORMAL, 0.
REQ-018 SHALL move FAULT -> NORMAL only when fault_clr=1 and the current cycle is legal; held pattern loads that input, illegal counter and flash counter clear.
REQ-019 fault_clr with an illegal input in FAULT SHALL be ignored; fault_clr in NORMAL SHALL be ignored.
REQ-020 Illegal input in the same cycle as a successful clear SHALL NOT occur by definition (REQ-018); an illegal cycle right after the clear restarts the count from 1.

Reset
REQ-021 On reset_n=0, asynchronously: state=NORMAL, held pattern all-zero, illegal, flash and PWM counters 0, all lamp outputs 0, fault=0.
REQ-022 Reset asserted mid-fault or mid-flash SHALL abort immediately to the REQ-021 values; first legal input after release drives lamps 1 cycle later.

Configuration
REQ-023 SHALL use macro LAMP_PWM_EN to compile PWM dimming in or out.
REQ-024 With LAMP_PWM_EN defined: a free-running PWM_BITS counter wraps max->0; a NORMAL-state lamp is on only while counter < duty_reg; duty_reg samples duty when counter is at max; duty=0 gives lamp always off; FAULT flashing is not PWM-gated.
REQ-025 Without LAMP_PWM_EN: no PWM counter or duty register; duty ignored; NORMAL lamps are full on per held pattern.

Verification
REQ-026 Reset release, red_in=1 only: lamp_red=1 one cycle after the first sampled edge; other lamps 0; fault=0.
REQ-027 Legal green, then red+green for 3 cycles, then green: lamp_green stays 1 throughout; fault never asserts (FAULT_CYCLES=4).
REQ-028 All inputs 0 for 4 cycles: fault=1 after the 4th edge; lamp_yellow is 1 for 50 cycles, 0 for 50, then 1; red and green lamps are 0.
REQ-029 In FAULT, fault_clr=1 with inputs 0: stays FAULT; then fault_clr=1 with yellow_in=1: NORMAL next cycle, fault=0, lamp_yellow=1.
REQ-030 With LAMP_PWM_EN, duty=64, green legal: lamp_green high for 64 of each 256 cycles; duty changes to 0 mid-period: takes effect only after the next wrap.
REQ-031 reset_n pulsed low for 3 ns mid-flash: all outputs 0 immediately, without waiting for clk.
